// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared state encoding, header layout and command bit positions
package jt6295_pkg;
  typedef enum logic [1:0] {IDLE, ARG, FETCH, ISSUE} state_t;
  localparam int HDR_LEN = 8;
  localparam int HDR_SH = $clog2(HDR_LEN);
  localparam int HDR_BYTES = 6;
  localparam logic [HDR_SH-1:0] HDR_START_HI = 3'd0;
  localparam logic [HDR_SH-1:0] HDR_START_MD = 3'd1;
  localparam logic [HDR_SH-1:0] HDR_START_LO = 3'd2;
  localparam logic [HDR_SH-1:0] HDR_STOP_HI = 3'd3;
  localparam logic [HDR_SH-1:0] HDR_STOP_MD = 3'd4;
  localparam logic [HDR_SH-1:0] HDR_STOP_LO = 3'd5;
  localparam int CMD_PHRASE = 7;
  localparam int STOP_LSB = 3;
  localparam int MASK_LSB = 4;
endpackage

// File: rtl/jt6295_wrdet.sv
// jt6295_wrdet: CPU write strobe rising-edge detector, presents din on the take clk
module jt6295_wrdet (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic [7:0] din,
  output logic       we,
  output logic [7:0] wdat
);
  logic wrn_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrn_q <= 1'b1;
    else wrn_q <= wrn;
  end
  always_comb begin
    we = ~wrn_q & wrn;
    wdat = din;
  end
endmodule

// File: rtl/jt6295_ctrl.sv
// jt6295_ctrl: OKI command decoder, phrase header fetch and slot-aligned channel start/stop
module jt6295_ctrl
  import jt6295_pkg::*;
#(
  parameter int HDR_AW = 18,
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_sr4,
  input  logic              wrn,
  input  logic [7:0]        din,
  input  logic [NCH-1:0]    ch_busy,
  output logic [HDR_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic [HDR_AW-1:0] start_addr,
  output logic [HDR_AW-1:0] stop_addr,
  output logic [3:0]        att,
  output logic [NCH-1:0]    start,
  output logic [NCH-1:0]    stop,
  output logic              ctrl_busy
);
  logic we;
  logic [7:0] wdat;
  state_t state_q, state_d;
  logic [6:0] phrase_q, phrase_d;
  logic [NCH-1:0] mask_q, mask_d, start_q, start_d, stop_q, stop_d;
  logic [3:0] att_arg_q, att_arg_d, att_q, att_d;
  logic [HDR_SH-1:0] hdr_byte_q, hdr_byte_d;
  logic [8*HDR_BYTES-1:0] hdr_q, hdr_d;
  logic [HDR_AW-1:0] rom_addr_q, rom_addr_d, start_addr_q, start_addr_d, stop_addr_q, stop_addr_d;
  logic rom_cs_q, rom_cs_d, stable_q, stable_d, ctrl_busy_q, ctrl_busy_d;

  jt6295_wrdet u_wrdet (.clk(clk), .rst(rst), .wrn(wrn), .din(din), .we(we), .wdat(wdat));

  always_comb begin
    state_d = state_q;
    phrase_d = phrase_q;
    mask_d = mask_q;
    att_arg_d = att_arg_q;
    hdr_byte_d = hdr_byte_q;
    hdr_d = hdr_q;
    rom_cs_d = rom_cs_q;
    start_addr_d = start_addr_q;
    stop_addr_d = stop_addr_q;
    att_d = att_q;
    start_d = '0;
    // stop commands bypass the FSM everywhere except where the byte is an argument
    stop_d = (we && !wdat[CMD_PHRASE] && state_q != ARG) ? wdat[STOP_LSB+:NCH] : '0;
    unique case (state_q)
      IDLE: if (we && wdat[CMD_PHRASE]) begin
        phrase_d = wdat[6:0];
        state_d = ARG;
      end
      ARG: if (we) begin
        mask_d = wdat[MASK_LSB+:NCH];
        att_arg_d = wdat[3:0];
        hdr_byte_d = HDR_START_HI;
        rom_cs_d = |wdat[MASK_LSB+:NCH];
        state_d = |wdat[MASK_LSB+:NCH] ? FETCH : IDLE;
      end
      FETCH: if (rom_ok && stable_q) begin
        hdr_d = {hdr_q[8*HDR_BYTES-9:0], rom_data};
        hdr_byte_d = hdr_byte_q + 1'b1;
        rom_cs_d = hdr_byte_q != HDR_STOP_LO;
        state_d = hdr_byte_q == HDR_STOP_LO ? ISSUE : FETCH;
      end
      ISSUE: if (cen_sr4) begin
        start_d = mask_q & ~ch_busy & ~stop_d;
        start_addr_d = hdr_q[24+:HDR_AW];
        stop_addr_d = hdr_q[0+:HDR_AW];
        att_d = att_arg_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rom_addr_d = state_d == FETCH ? HDR_AW'({phrase_q, hdr_byte_d}) : rom_addr_q;
    // rom_ok seen in the first clk after an address change may belong to the old address
    stable_d = state_q == FETCH && rom_addr_d == rom_addr_q;
    ctrl_busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phrase_q <= '0;
      mask_q <= '0;
      att_arg_q <= '0;
      hdr_byte_q <= '0;
      hdr_q <= '0;
      rom_addr_q <= '0;
      rom_cs_q <= 1'b0;
      stable_q <= 1'b0;
      start_addr_q <= '0;
      stop_addr_q <= '0;
      att_q <= '0;
      start_q <= '0;
      stop_q <= '0;
      ctrl_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phrase_q <= phrase_d;
      mask_q <= mask_d;
      att_arg_q <= att_arg_d;
      hdr_byte_q <= hdr_byte_d;
      hdr_q <= hdr_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q <= rom_cs_d;
      stable_q <= stable_d;
      start_addr_q <= start_addr_d;
      stop_addr_q <= stop_addr_d;
      att_q <= att_d;
      start_q <= start_d;
      stop_q <= stop_d;
      ctrl_busy_q <= ctrl_busy_d;
    end
  end

  always_comb begin
    rom_addr = rom_addr_q;
    rom_cs = rom_cs_q;
    start_addr = start_addr_q;
    stop_addr = stop_addr_q;
    att = att_q;
    start = start_q;
    stop = stop_q;
    ctrl_busy = ctrl_busy_q;
  end
endmodule

// File: tb/tb_jt6295_ctrl.sv
// tb_jt6295_ctrl: randomized scenario bench with a behavioural ROM and header model
module tb_jt6295_ctrl;
  logic clk = 1'b0, rst = 1'b1, cen_sr4 = 1'b0, wrn = 1'b1;
  logic [7:0] din = '0, rom_data;
  logic [3:0] ch_busy = '0, att, start, stop;
  logic [17:0] rom_addr, start_addr, stop_addr, last_addr = '0;
  logic rom_cs, rom_ok, ctrl_busy;
  logic [7:0] mem [0:1023];
  int checks = 0, errors = 0, lat = 0, wait_cnt = 0;
  bit spur = 1'b0;

  always #5 clk = ~clk;

  jt6295_ctrl #(.HDR_AW(18), .NCH(4)) dut (
    .clk(clk), .rst(rst), .cen_sr4(cen_sr4), .wrn(wrn), .din(din), .ch_busy(ch_busy),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .start(start), .stop(stop),
    .ctrl_busy(ctrl_busy)
  );

  // ROM answers lat clks after it sees an address; spur keeps stale data flagged valid meanwhile
  always @(posedge clk) begin
    if (rom_addr != last_addr) begin
      last_addr <= rom_addr;
      wait_cnt <= lat;
    end else if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
  end
  assign rom_ok = rom_cs && wait_cnt == 0 && (spur || rom_addr == last_addr);
  assign rom_data = mem[last_addr[9:0]];

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wrn = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_fetch(output logic [17:0] seen [$]);
    seen = {};
    for (int i = 0; i < 500 && rom_cs; i++) begin
      if (seen.size() == 0 || seen[$] != rom_addr) seen.push_back(rom_addr);
      @(negedge clk);
    end
    checks++;
    if (rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout: rom_cs=%b required 0", rom_cs);
    end
  endtask

  task automatic check_issue(input logic [6:0] ph, input logic [7:0] arg, input logic [3:0] busy, input logic [3:0] stp, input string tag);
    int base;
    logic [23:0] s, e;
    logic [3:0] exp_start;
    base = int'(ph) * 8;
    s = {mem[base], mem[base+1], mem[base+2]};
    e = {mem[base+3], mem[base+4], mem[base+5]};
    exp_start = arg[7:4] & ~busy & ~stp;
    checks++;
    if (start !== exp_start || stop !== stp) begin
      errors++;
      $display("FAIL %s strobes: start=%b stop=%b required start=%b stop=%b", tag, start, stop, exp_start, stp);
    end
    checks++;
    if (start_addr !== s[17:0] || stop_addr !== e[17:0] || att !== arg[3:0]) begin
      errors++;
      $display("FAIL %s bus: start_addr=%h stop_addr=%h att=%h required %h %h %h", tag, start_addr, stop_addr, att, s[17:0], e[17:0], arg[3:0]);
    end
    checks++;
    if (ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: ctrl_busy=%b required 0", tag, ctrl_busy);
    end
    @(negedge clk);
    checks++;
    if (start !== 4'b0000 || stop !== 4'b0000) begin
      errors++;
      $display("FAIL %s pulse_width: start=%b stop=%b required 0000 0000", tag, start, stop);
    end
  endtask

  task automatic do_play(input logic [6:0] ph, input logic [7:0] arg, input logic [3:0] busy, input int l, input bit sp, input string tag);
    logic [17:0] seen [$];
    bit ok;
    lat = l;
    spur = sp;
    ch_busy = busy;
    wr({1'b1, ph});
    checks++;
    if (ctrl_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s arg_busy: ctrl_busy=%b required 1", tag, ctrl_busy);
    end
    wr(arg);
    if (arg[7:4] == 4'h0) begin
      checks++;
      if (ctrl_busy !== 1'b0 || rom_cs !== 1'b0) begin
        errors++;
        $display("FAIL %s mask0: ctrl_busy=%b rom_cs=%b required 0 0", tag, ctrl_busy, rom_cs);
      end
      return;
    end
    wait_fetch(seen);
    ok = seen.size() == 6;
    for (int i = 0; i < seen.size() && i < 6; i++) ok &= seen[i] == 18'(int'(ph) * 8 + i);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s walk: %0d addresses starting %h required 6 starting %h", tag, seen.size(), seen.size() ? seen[0] : 18'h0, 18'(int'(ph) * 8));
    end
    checks++;
    if (ctrl_busy !== 1'b1 || start !== 4'b0000) begin
      errors++;
      $display("FAIL %s issue_wait: ctrl_busy=%b start=%b required 1 0000", tag, ctrl_busy, start);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    cen_sr4 = 1'b1;
    @(negedge clk);
    cen_sr4 = 1'b0;
    check_issue(ph, arg, busy, 4'b0000, tag);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({start, stop, rom_cs, ctrl_busy, att, rom_addr, start_addr, stop_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs nonzero start=%b stop=%b rom_cs=%b busy=%b", start, stop, rom_cs, ctrl_busy);
    end
    rst = 1'b0;
    lat = 3;
    wr(8'h85);
    wr(8'hF3);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (start !== 4'b0 || stop !== 4'b0 || rom_cs !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midfetch: start=%b stop=%b rom_cs=%b busy=%b required all 0", start, stop, rom_cs, ctrl_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    do_play(7'h05, 8'hF3, 4'b0000, 1, 1'b0, "after_reset");
  endtask

  task automatic test_play;
    mem[16'h0A8] = 8'h00; mem[16'h0A9] = 8'h01; mem[16'h0AA] = 8'h00;
    mem[16'h0AB] = 8'h00; mem[16'h0AC] = 8'h02; mem[16'h0AD] = 8'h00;
    do_play(7'h15, 8'h3A, 4'b0000, 0, 1'b0, "play");
    checks++;
    if (start_addr !== 18'h00100 || stop_addr !== 18'h00200 || att !== 4'hA) begin
      errors++;
      $display("FAIL play_const: start_addr=%h stop_addr=%h att=%h required 00100 00200 a", start_addr, stop_addr, att);
    end
  endtask

  task automatic test_busy_drop;
    do_play(7'h01, 8'hF0, 4'b0001, 0, 1'b0, "busy_drop");
  endtask

  task automatic test_stop;
    wr(8'h48);
    checks++;
    if (stop !== 4'b1001 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: stop=%b busy=%b required 1001 0", stop, ctrl_busy);
    end
    @(negedge clk);
    checks++;
    if (stop !== 4'b0000) begin
      errors++;
      $display("FAIL stop_width: stop=%b required 0000", stop);
    end
  endtask

  task automatic test_collision;
    logic [17:0] seen [$];
    lat = 0;
    spur = 1'b0;
    ch_busy = 4'b0000;
    wr(8'h92);
    wr(8'h10);
    wait_fetch(seen);
    @(negedge clk);
    din = 8'h08;
    wrn = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
    cen_sr4 = 1'b1;
    @(negedge clk);
    cen_sr4 = 1'b0;
    check_issue(7'h12, 8'h10, 4'b0000, 4'b0001, "collision");
  endtask

  task automatic test_slow_rom;
    mem[16'h0A8] = 8'h00; mem[16'h0A9] = 8'h01; mem[16'h0AA] = 8'h00;
    mem[16'h0AB] = 8'h00; mem[16'h0AC] = 8'h02; mem[16'h0AD] = 8'h00;
    do_play(7'h15, 8'h7C, 4'b0000, 5, 1'b1, "slow_rom");
    checks++;
    if (start_addr !== 18'h00100 || stop_addr !== 18'h00200) begin
      errors++;
      $display("FAIL slow_rom_const: start_addr=%h stop_addr=%h required 00100 00200", start_addr, stop_addr);
    end
  endtask

  task automatic test_cmds_in_fetch;
    logic [17:0] seen [$];
    lat = 4;
    spur = 1'b0;
    ch_busy = 4'b0000;
    wr(8'hC0);
    wr(8'hF5);
    wr(8'h30);
    checks++;
    if (stop !== 4'b0110 || rom_cs !== 1'b1) begin
      errors++;
      $display("FAIL stop_in_fetch: stop=%b rom_cs=%b required 0110 1", stop, rom_cs);
    end
    wr(8'h83);
    wait_fetch(seen);
    cen_sr4 = 1'b1;
    @(negedge clk);
    cen_sr4 = 1'b0;
    check_issue(7'h40, 8'hF5, 4'b0000, 4'b0000, "phrase_drop");
  endtask

  task automatic test_random;
    logic [7:0] arg;
    do_play(7'h7F, 8'h8E, 4'b0100, 1, 1'b1, "phrase127");
    for (int n = 0; n < 16; n++) begin
      arg = 8'($urandom);
      do_play(7'($urandom), arg, 4'($urandom), $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    test_reset;
    test_play;
    test_busy_drop;
    test_stop;
    test_collision;
    test_slow_rom;
    test_cmds_in_fetch;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
